// File: rtl/dsm_mac_sched.sv
// Per-sample scheduler for the sigma-delta modulator: walks the integrator stages
// through one shared MAC (request, acknowledge, writeback), then fires the quantizer latch.
module dsm_mac_sched #(
  parameter int NSTAGE = 6,
  parameter int MAC_TO = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fs_enb,
  input  logic        mac_ack,
  input  logic        err_clr,
  output logic        mac_req,
  output logic [2:0]  stage_idx,
  output logic        st_wr,
  output logic        quant_enb,
  output logic        busy,
  output logic        overrun,
  output logic        mac_err,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WB,
    S_QUANT,
    S_ABORT
  } state_e;

  localparam logic [2:0] LAST_STAGE = 3'(NSTAGE - 1);
  localparam logic [7:0] TO_LAST    = 8'(MAC_TO - 1);

  state_e      state_q, state_d;
  logic [2:0]  stage_q, stage_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        overrun_q, overrun_d;
  logic        mac_err_q, mac_err_d;
  logic        mac_req_q, st_wr_q, quant_enb_q, busy_q;

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    overrun_d = overrun_q;
    mac_err_d = mac_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (fs_enb) begin
          state_d = S_REQ;
          stage_d = 3'd0;
          cnt_d   = 8'd0;
        end
      end
      S_REQ: begin
        // An acknowledge on the last allowed cycle still completes the stage.
        if (mac_ack) begin
          state_d = S_WB;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        if (stage_q == LAST_STAGE) begin
          state_d = S_QUANT;
        end else begin
          stage_d = stage_q + 3'd1;
          cnt_d   = 8'd0;
          state_d = S_REQ;
        end
      end
      S_QUANT: begin
        fcnt_d  = fcnt_q + 16'd1;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Sticky flags: a setting event on the same cycle as err_clr wins.
    if (err_clr) begin
      overrun_d = 1'b0;
      mac_err_d = 1'b0;
    end
    if (fs_enb && busy_q) begin
      overrun_d = 1'b1;
    end
    if (state_q == S_ABORT) begin
      mac_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      stage_q     <= 3'd0;
      cnt_q       <= 8'd0;
      fcnt_q      <= 16'd0;
      overrun_q   <= 1'b0;
      mac_err_q   <= 1'b0;
      mac_req_q   <= 1'b0;
      st_wr_q     <= 1'b0;
      quant_enb_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      overrun_q   <= overrun_d;
      mac_err_q   <= mac_err_d;
      mac_req_q   <= (state_d == S_REQ);
      st_wr_q     <= (state_d == S_WB);
      quant_enb_q <= (state_d == S_QUANT);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign mac_req   = mac_req_q;
  assign stage_idx = stage_q;
  assign st_wr     = st_wr_q;
  assign quant_enb = quant_enb_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign mac_err   = mac_err_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_dsm_mac_sched.sv
// Scoreboard bench for dsm_mac_sched: a frame-level model predicts writeback, quantize
// and abort events (stage, cycle, request length); a monitor pops and compares them.
module tb_dsm_mac_sched;

  localparam int NSTAGE = 6;
  localparam int MAC_TO = 15;
  localparam int K_WR = 0, K_QUANT = 1, K_ABORT = 2;

  logic        clk = 1'b0;
  logic        rst_n, fs_enb, mac_ack, err_clr;
  logic        mac_req, st_wr, quant_enb, busy, overrun, mac_err;
  logic [2:0]  stage_idx;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  dsm_mac_sched #(.NSTAGE(NSTAGE), .MAC_TO(MAC_TO)) dut (
    .clk(clk), .rst_n(rst_n), .fs_enb(fs_enb), .mac_ack(mac_ack), .err_clr(err_clr),
    .mac_req(mac_req), .stage_idx(stage_idx), .st_wr(st_wr), .quant_enb(quant_enb),
    .busy(busy), .overrun(overrun), .mac_err(mac_err), .frame_cnt(frame_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int idx;
    int cyc;
    int run;
    int fcnt;
  } ev_t;

  ev_t exp_q[$];
  int  dly[8];
  int  fcnt_m = 0;
  bit  err_m  = 1'b0;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // MAC model: acknowledges dly[stage] cycles into each request; random ack noise otherwise.
  initial begin
    int rc;
    rc = 0;
    mac_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mac_req) begin
        mac_ack = (rc == dly[stage_idx]);
        rc++;
      end else begin
        mac_ack = 1'($urandom_range(0, 1));
        rc = 0;
      end
    end
  end

  // Monitor: classify each cycle's outputs and compare against the expected event queue.
  initial begin
    int  run;
    int  k;
    ev_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
      end else begin
        if (mac_req) run++;
        k = st_wr ? K_WR : quant_enb ? K_QUANT : (busy && !mac_req) ? K_ABORT : -1;
        if (k >= 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (k == K_QUANT) begin
              check("frame_cnt_in_quant", int'(frame_cnt), e.fcnt);
            end else begin
              check("event_stage", int'(stage_idx), e.idx);
              check("req_len", run, e.run);
            end
          end
          if (k != K_QUANT) run = 0;
        end
      end
    end
  end

  // Reference model: a frame is a chain of requests lasting min(delay+1, MAC_TO) cycles,
  // each followed by one writeback cycle, ending in quantize or abort. Stages at or
  // beyond 'cut' are never reached (reset intervenes).
  task automatic issue_frame(input int cut);
    int acc;
    int len;
    bit ab;
    ab = 1'b0;
    @(negedge clk);
    fs_enb = 1'b1;
    acc = cyc + 1;
    for (int s = 0; s < NSTAGE; s++) begin
      if (s >= cut) break;
      len = (dly[s] >= MAC_TO) ? MAC_TO : dly[s] + 1;
      acc += len;
      if (dly[s] >= MAC_TO) begin
        exp_q.push_back('{K_ABORT, s, acc, len, 0});
        ab = 1'b1;
        err_m = 1'b1;
        break;
      end
      exp_q.push_back('{K_WR, s, acc, len, 0});
      acc += 1;
    end
    if (!ab && cut >= NSTAGE) begin
      exp_q.push_back('{K_QUANT, 0, acc, 0, fcnt_m});
      fcnt_m = (fcnt_m + 1) % 65536;
    end
    @(negedge clk);
    fs_enb = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic set_dly(input int v);
    for (int s = 0; s < 8; s++) dly[s] = v;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mac_req"}, int'(mac_req), 0);
    check({tag, "_st_wr"}, int'(st_wr), 0);
    check({tag, "_quant_enb"}, int'(quant_enb), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_mac_err"}, int'(mac_err), 0);
    check({tag, "_stage_idx"}, int'(stage_idx), 0);
    check({tag, "_frame_cnt"}, int'(frame_cnt), 0);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    fs_enb  = 1'b0;
    err_clr = 1'b0;
    set_dly(0);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Ack tied high: 13-cycle frame.
    issue_frame(NSTAGE);
    wait_idle();
    check("fast_frame_cnt", int'(frame_cnt), fcnt_m);
    check("fast_overrun", int'(overrun), 0);

    // Three-cycle MAC latency per stage.
    set_dly(3);
    issue_frame(NSTAGE);
    wait_idle();
    check("slow_frame_cnt", int'(frame_cnt), fcnt_m);
    check("slow_mac_err", int'(mac_err), 0);
    check("slow_overrun", int'(overrun), 0);

    // Second strobe five cycles into a frame is dropped and flagged.
    set_dly(0);
    issue_frame(NSTAGE);
    repeat (4) @(negedge clk);
    fs_enb = 1'b1;
    @(negedge clk);
    fs_enb = 1'b0;
    wait_idle();
    check("overrun_set", int'(overrun), 1);
    check("overrun_frame_cnt", int'(frame_cnt), fcnt_m);
    pulse_clr();
    check("overrun_cleared", int'(overrun), 0);

    // Overrun set and err_clr on the same cycle: set wins.
    issue_frame(NSTAGE);
    repeat (2) @(negedge clk);
    fs_enb  = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    fs_enb  = 1'b0;
    err_clr = 1'b0;
    check("overrun_set_wins", int'(overrun), 1);
    wait_idle();
    pulse_clr();
    check("overrun_cleared2", int'(overrun), 0);

    // MAC withheld on stage 2: abort after MAC_TO request cycles.
    dly[2] = 99;
    issue_frame(NSTAGE);
    wait_idle();
    check("timeout_mac_err", int'(mac_err), 1);
    check("timeout_frame_cnt", int'(frame_cnt), fcnt_m);
    check("timeout_overrun", int'(overrun), 0);
    set_dly(0);
    issue_frame(NSTAGE);
    wait_idle();
    check("after_timeout_frame_cnt", int'(frame_cnt), fcnt_m);
    pulse_clr();
    err_m = 1'b0;
    check("mac_err_cleared", int'(mac_err), 0);

    // Asynchronous reset during the stage-3 request.
    dly[3] = 10;
    issue_frame(3);
    n = 0;
    while (!(mac_req && stage_idx == 3'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_stage3_req", int'(mac_req && stage_idx == 3'd3), 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("midframe_reset");
    fcnt_m = 0;
    err_m  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_dly(0);
    repeat (20) @(negedge clk);
    check("post_reset_idle", int'(busy), 0);
    issue_frame(NSTAGE);
    wait_idle();
    check("post_reset_frame_cnt", int'(frame_cnt), fcnt_m);

    // Randomized frames with occasional MAC timeouts.
    for (int f = 0; f < 30; f++) begin
      for (int s = 0; s < NSTAGE; s++) begin
        dly[s] = ($urandom_range(0, 11) == 0) ? 99 : int'($urandom_range(0, 4));
      end
      issue_frame(NSTAGE);
      wait_idle();
      check("rand_frame_cnt", int'(frame_cnt), fcnt_m);
      check("rand_mac_err", int'(mac_err), int'(err_m));
      check("rand_overrun", int'(overrun), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("pending_events", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
